// File: rtl/wb_queue_stage.sv
// Write-back queue between MEM and the register file: DEPTH-entry in-order buffer
// drained one entry per granted cycle, with byte strobes and multi-port forwarding lookup.
module wb_queue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned NUM_Q  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         ms_to_ws_valid,
  output logic                         ws_allowin,
  input  logic [3:0]                   ms_gr_strb,
  input  logic [4:0]                   ms_dest,
  input  logic [DATA_W-1:0]            ms_result,
  input  logic [PC_W-1:0]              ms_pc,
  input  logic                         rf_ready,
  output logic [3:0]                   rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [PC_W-1:0]              debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [4:0]                   debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata,
  input  logic [NUM_Q*5-1:0]           q_addr,
  output logic [NUM_Q-1:0]             q_hit,
  output logic [NUM_Q-1:0]             q_partial,
  output logic [NUM_Q*DATA_W-1:0]      q_data,
  output logic [$clog2(DEPTH+1)-1:0]   ws_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [3:0]        r_strb [DEPTH];
  logic [4:0]        r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_enq;
  logic              w_drain;
  logic [PTR_W-1:0]  w_idx;
  logic [4:0]        w_qa;
  int unsigned       w_count_u;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ws_allowin = (r_count != CNT_W'(DEPTH));
  assign w_enq      = ms_to_ws_valid && ws_allowin && !flush;
  // Reset cycle must never write the register file, even with a stale occupied head.
  assign w_drain    = !reset && (r_count != '0) && rf_ready;
  assign w_count_u  = 32'(r_count);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_drain) begin
        r_head <= ptr_inc(r_head);
      end
      if (w_enq && !w_drain) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_drain) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Payload is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_strb[r_tail] <= ms_gr_strb;
      r_dest[r_tail] <= ms_dest;
      r_data[r_tail] <= ms_result;
      r_pc[r_tail]   <= ms_pc;
    end
  end

  assign rf_we             = r_strb[r_head] & {4{w_drain}};
  assign rf_waddr          = r_dest[r_head];
  assign rf_wdata          = r_data[r_head];
  assign debug_wb_pc       = r_pc[r_head];
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign ws_count          = reset ? '0 : r_count;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    q_hit     = '0;
    q_partial = '0;
    q_data    = '0;
    w_idx     = '0;
    w_qa      = '0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      w_qa = q_addr[5*q +: 5];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        w_idx = PTR_W'((32'(r_head) + k) % DEPTH);
        if (!reset && (k < w_count_u) && (r_strb[w_idx] != 4'h0) &&
            (r_dest[w_idx] == w_qa) && (w_qa != 5'd0)) begin
          q_hit[q]                   = 1'b1;
          q_partial[q]               = (r_strb[w_idx] != 4'hF);
          q_data[DATA_W*q +: DATA_W] = r_data[w_idx];
        end
      end
    end
  end

endmodule
